detector_jogada: RTL and testbench
==================================

// Module: detector_jogada
// PURPOSE
//   Front-end play detector between the board switches and the game datapath/controller.
//   - Synchronizes and debounces the 4 switches.
//   - Emits a one-cycle jogada_feita pulse per accepted press and holds the registered play value.
//   - Re-arms only after all switches are released and stable.
// PARAMETERS
//   DEBOUNCE_CYCLES  4  consecutive stable synchronized cycles required to accept a press or a release (>=1)
//   LARGURA          4  switch/play width
// PORTS
//   clock          in   1        system clock
//   reset          in   1        synchronous, active-high reset
//   chaves         in   LARGURA  raw asynchronous switches
//   habilita       in   1        controller allows a new play to be accepted
//   jogada_feita   out  1        one-cycle pulse: play accepted
//   jogada         out  LARGURA  last accepted play; held until the next accepted play
//   db_tem_jogada  out  1        1 while synchronized switches are nonzero
//   db_estado      out  4        FSM state code, for hexa7seg
// BEHAVIOUR
//   Reset values
//   - Reset is synchronous and active-high; clock is the only clock.
//   - On reset: jogada=0, jogada_feita=0, db_estado=0, counter=0, sync FFs=0.
//   - Reset mid-operation aborts any count; no pulse is emitted on the reset cycle or the cycle after it.
//   Synchronization
//   - chaves passes through 2 FFs to give sinc (2-cycle latency).
//   - Every decision below uses sinc only.
//   States (db_estado)
//   - INICIAL(0): count=0. If sinc!=0 and habilita=1: capture candidate=sinc, count=1, go to ESTABILIZA. If sinc!=0 and habilita=0: go to SOLTAR.
//   - ESTABILIZA(1): if sinc==candidate, count++. If sinc!=candidate and nonzero: candidate=sinc, count=1. If sinc==0: go to INICIAL.
//     When count reaches DEBOUNCE_CYCLES, go to REGISTRA. If habilita drops, go to SOLTAR with no pulse.
//   - REGISTRA(2): jogada<=candidate, jogada_feita=1 for exactly this cycle, count=0, go to SOLTAR.
//   - SOLTAR(3): count++ while sinc==0, reset count to 0 when sinc!=0. When count reaches DEBOUNCE_CYCLES, go to INICIAL. Never pulses.
//   - INVALIDA(4): present only with the macro; see CONFIGURATION.
//   - Unused codes fall back to INICIAL.
//   Latency
//   - Switch stable at V!=0 from cycle t with habilita=1 in INICIAL: jogada_feita=1 at cycle t+2+DEBOUNCE_CYCLES.
//   - jogada=V from the same edge.
//   Boundaries
//   - Glitches shorter than DEBOUNCE_CYCLES produce no pulse.
//   - A held switch produces exactly one pulse.
//   - Changing keys without a full release produces no second pulse.
//   - The counter saturates at DEBOUNCE_CYCLES and never wraps.
//   - Counter width is $clog2(DEBOUNCE_CYCLES+1).
// CONFIGURATION
//   Macro JOGADA_ONEHOT_CHECK_EN
//   - Defined: in ESTABILIZA, a candidate that is not one-hot and reaches DEBOUNCE_CYCLES goes to INVALIDA(4).
//     INVALIDA goes to SOLTAR the next cycle, with no jogada_feita pulse and jogada unchanged.
//   - Undefined: any stable nonzero pattern is accepted and registered as-is; state 4 does not exist.
// STRUCTURE
//   Shared package jogada_pkg holds:
//   - state encodings E_INICIAL..E_INVALIDA (4-bit);
//   - the default LARGURA;
//   - the one-hot check function.
//   One sub-module: sincronizador_2ff, parameterized by width, holding the 2-stage synchronizer.
//   FSM, counter and play register live in detector_jogada.
// TESTING (DEBOUNCE_CYCLES=4, habilita=1 unless stated)
//   1. Reset, then hold chaves=4'b0010 from cycle 10.
//      -> One pulse at cycle 16; jogada=2 held.
//      -> Release gives db_estado 3 then 0 after 4 zero cycles; no further pulse.
//   2. Glitch chaves=4'b0100 for 3 cycles, then 0.
//      -> No pulse; jogada unchanged; db_estado returns to 0.
//   3. Press 4'b0001 for 2 cycles, switch to 4'b1000 and hold.
//      -> Single pulse with jogada=8, 4 cycles after 1000 first reaches sinc.
//   4. habilita=0 while pressing 4'b0001.
//      -> No pulse, state SOLTAR.
//      -> Raise habilita while still pressed: no pulse until release plus 4 zero cycles, then a new press is accepted.
//   5. Assert reset on the cycle before an expected pulse.
//      -> No pulse; all outputs 0; db_estado=0.
//   6. Hold 4'b0011.
//      -> With JOGADA_ONEHOT_CHECK_EN: db_estado shows 4 for one cycle, no pulse, jogada unchanged.
//      -> Without the macro: pulse with jogada=3.

Source files
------------

// File: rtl/jogada_pkg.sv
// Shared types and helpers for the play detector.
// Optional JOGADA_ONEHOT_CHECK_EN adds the INVALIDA state.
package jogada_pkg;

  localparam int LARGURA_PADRAO = 4;

  typedef enum logic [3:0] {
    E_INICIAL    = 4'd0,
    E_ESTABILIZA = 4'd1,
    E_REGISTRA   = 4'd2,
    E_SOLTAR     = 4'd3
`ifdef JOGADA_ONEHOT_CHECK_EN
    , E_INVALIDA = 4'd4
`endif
  } estado_t;

  function automatic logic eh_um_quente(
    input logic [31:0] v
  );
    return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/sincronizador_2ff.sv
// Two-stage synchronizer for the raw switch inputs.
// Both stages clear on synchronous reset.
module sincronizador_2ff #(
  parameter int LARGURA = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [LARGURA-1:0] d,
  output logic [LARGURA-1:0] q
);

  logic [LARGURA-1:0] meta;

  always_ff @(posedge clock) begin
    if (reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/detector_jogada.sv
// Debounced play detector: one pulse per accepted press.
// Define JOGADA_ONEHOT_CHECK_EN to reject non-one-hot plays.
module detector_jogada
  import jogada_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int LARGURA         = LARGURA_PADRAO
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [LARGURA-1:0] chaves,
  input  logic               habilita,
  output logic               jogada_feita,
  output logic [LARGURA-1:0] jogada,
  output logic               db_tem_jogada,
  output logic [3:0]         db_estado
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] D_MAX = CW'(DEBOUNCE_CYCLES);

  logic [LARGURA-1:0] sinc;
  logic [LARGURA-1:0] cand, cand_nxt;
  logic [CW-1:0]      cnt, cnt_nxt, cnt_inc;
  logic               alcancou, aceita_ok;
  estado_t            estado, estado_nxt;

  sincronizador_2ff #(
    .LARGURA(LARGURA)
  ) u_sinc (
    .clock(clock),
    .reset(reset),
    .d    (chaves),
    .q    (sinc)
  );

  assign db_tem_jogada = |sinc;
  assign cnt_inc = (cnt == D_MAX) ? D_MAX : cnt + 1'b1;

  always_ff @(posedge clock) begin
    if (reset) begin
      estado <= E_INICIAL;
      cnt    <= '0;
      cand   <= '0;
      jogada <= '0;
    end else begin
      estado <= estado_nxt;
      cnt    <= cnt_nxt;
      cand   <= cand_nxt;
      if (estado_nxt == E_REGISTRA)
        jogada <= cand_nxt;
    end
  end

`ifdef JOGADA_ONEHOT_CHECK_EN
  assign aceita_ok = eh_um_quente(32'(cand_nxt));
`else
  assign aceita_ok = 1'b1;
`endif

  always_comb begin
    estado_nxt = estado;
    cnt_nxt    = cnt;
    cand_nxt   = cand;
    alcancou   = 1'b0;
    unique case (estado)
      E_INICIAL: begin
        cnt_nxt = '0;
        if (db_tem_jogada) begin
          if (habilita) begin
            cand_nxt   = sinc;
            cnt_nxt    = CW'(1);
            estado_nxt = E_ESTABILIZA;
            alcancou   = (CW'(1) == D_MAX);
          end else begin
            estado_nxt = E_SOLTAR;
          end
        end
      end
      E_ESTABILIZA: begin
        if (!db_tem_jogada) begin
          cnt_nxt    = '0;
          estado_nxt = E_INICIAL;
        end else if (!habilita) begin
          cnt_nxt    = '0;
          estado_nxt = E_SOLTAR;
        end else if (sinc == cand) begin
          cnt_nxt  = cnt_inc;
          alcancou = (cnt_inc == D_MAX);
        end else begin
          cand_nxt = sinc;
          cnt_nxt  = CW'(1);
          alcancou = (CW'(1) == D_MAX);
        end
      end
      E_REGISTRA: begin
        cnt_nxt    = '0;
        estado_nxt = E_SOLTAR;
      end
      E_SOLTAR: begin
        if (db_tem_jogada) begin
          cnt_nxt = '0;
        end else if (cnt_inc == D_MAX) begin
          cnt_nxt    = '0;
          estado_nxt = E_INICIAL;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
`ifdef JOGADA_ONEHOT_CHECK_EN
      E_INVALIDA: begin
        cnt_nxt    = '0;
        estado_nxt = E_SOLTAR;
      end
`endif
      default: begin
        cnt_nxt    = '0;
        estado_nxt = E_INICIAL;
      end
    endcase
    // Debounce window complete: accept, or reject a non-one-hot play
    if (alcancou) begin
`ifdef JOGADA_ONEHOT_CHECK_EN
      estado_nxt = aceita_ok ? E_REGISTRA : E_INVALIDA;
`else
      estado_nxt = aceita_ok ? E_REGISTRA : E_SOLTAR;
`endif
    end
  end

  always_comb begin
    jogada_feita = (estado == E_REGISTRA) && !reset;
    db_estado    = estado;
  end

endmodule

// File: tb/tb_detector_jogada.sv
// Directed bench for detector_jogada (DEBOUNCE_CYCLES=4).
// Cycle n = interval after the n-th rising clock edge.
module tb_detector_jogada;

  logic       clock;
  logic       reset;
  logic [3:0] chaves;
  logic       habilita;
  logic       jogada_feita;
  logic [3:0] jogada;
  logic       db_tem_jogada;
  logic [3:0] db_estado;

  int ciclo  = 0;
  int pulsos = 0;
  int checks = 0;
  int errors = 0;
  int p0;

  detector_jogada #(
    .DEBOUNCE_CYCLES(4),
    .LARGURA        (4)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .chaves       (chaves),
    .habilita     (habilita),
    .jogada_feita (jogada_feita),
    .jogada       (jogada),
    .db_tem_jogada(db_tem_jogada),
    .db_estado    (db_estado)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) ciclo <= ciclo + 1;

  always @(negedge clock)
    if (jogada_feita === 1'b1) pulsos <= pulsos + 1;

  initial begin
    #20000;
    $display("FAIL watchdog: ciclo=%0d required=<2000", ciclo);
    $fatal(1, "timeout");
  end

  task automatic ate(input int n);
    while (ciclo < n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic na(input int n);
    ate(n);
    @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset    = 1'b1;
    chaves   = 4'b0000;
    habilita = 1'b1;
    ate(2);
    reset = 1'b0;
    na(3);
    chk("rst_jogada", 32'(jogada), 0);
    chk("rst_pulse", 32'(jogada_feita), 0);
    chk("rst_estado", 32'(db_estado), 0);
    chk("rst_tem", 32'(db_tem_jogada), 0);

    // 1: held press
    ate(10);
    chaves = 4'b0010;
    na(11);
    chk("t1_tem_c11", 32'(db_tem_jogada), 0);
    na(12);
    chk("t1_tem_c12", 32'(db_tem_jogada), 1);
    na(15);
    chk("t1_nopulse_c15", 32'(jogada_feita), 0);
    chk("t1_estado_c15", 32'(db_estado), 1);
    na(16);
    chk("t1_pulse_c16", 32'(jogada_feita), 1);
    chk("t1_jogada_c16", 32'(jogada), 2);
    chk("t1_estado_c16", 32'(db_estado), 2);
    na(17);
    chk("t1_pulse_c17", 32'(jogada_feita), 0);
    chk("t1_estado_c17", 32'(db_estado), 3);
    ate(20);
    chaves = 4'b0000;
    na(25);
    chk("t1_estado_c25", 32'(db_estado), 3);
    na(26);
    chk("t1_estado_c26", 32'(db_estado), 0);
    chk("t1_jogada_hold", 32'(jogada), 2);
    ate(30);
    chk("t1_pulse_count", 32'(pulsos), 1);

    // 2: 3-cycle glitch
    chaves = 4'b0100;
    ate(33);
    chaves = 4'b0000;
    na(35);
    chk("t2_estado_c35", 32'(db_estado), 1);
    na(36);
    chk("t2_estado_c36", 32'(db_estado), 0);
    ate(40);
    chk("t2_no_pulse", 32'(pulsos), 1);
    chk("t2_jogada", 32'(jogada), 2);

    // 3: key change without release
    chaves = 4'b0001;
    ate(42);
    chaves = 4'b1000;
    na(47);
    chk("t3_nopulse_c47", 32'(jogada_feita), 0);
    na(48);
    chk("t3_pulse_c48", 32'(jogada_feita), 1);
    chk("t3_jogada_c48", 32'(jogada), 8);
    ate(55);
    chk("t3_single_pulse", 32'(pulsos), 2);
    chaves = 4'b0000;
    ate(63);

    // 4: habilita low
    habilita = 1'b0;
    chaves   = 4'b0001;
    na(67);
    chk("t4_estado_c67", 32'(db_estado), 3);
    ate(70);
    habilita = 1'b1;
    na(75);
    chk("t4_estado_c75", 32'(db_estado), 3);
    ate(76);
    chk("t4_no_pulse", 32'(pulsos), 2);
    chaves = 4'b0000;
    na(81);
    chk("t4_estado_c81", 32'(db_estado), 3);
    na(82);
    chk("t4_estado_c82", 32'(db_estado), 0);
    ate(84);
    chaves = 4'b0100;
    na(90);
    chk("t4_pulse_c90", 32'(jogada_feita), 1);
    chk("t4_jogada_c90", 32'(jogada), 4);
    ate(91);
    chaves = 4'b0000;
    ate(100);

    // 5: reset just before the pulse
    p0 = pulsos;
    chaves = 4'b0010;
    ate(105);
    reset = 1'b1;
    ate(106);
    reset  = 1'b0;
    chaves = 4'b0000;
    @(negedge clock);
    chk("t5_pulse_c106", 32'(jogada_feita), 0);
    chk("t5_jogada_c106", 32'(jogada), 0);
    chk("t5_estado_c106", 32'(db_estado), 0);
    chk("t5_tem_c106", 32'(db_tem_jogada), 0);
    na(107);
    chk("t5_pulse_c107", 32'(jogada_feita), 0);
    ate(112);
    chk("t5_no_pulse", 32'(pulsos - p0), 0);

    // 6: non-one-hot play
    chaves = 4'b0011;
    na(118);
`ifdef JOGADA_ONEHOT_CHECK_EN
    chk("t6_estado_c118", 32'(db_estado), 4);
    chk("t6_pulse_c118", 32'(jogada_feita), 0);
    chk("t6_jogada_c118", 32'(jogada), 0);
`else
    chk("t6_estado_c118", 32'(db_estado), 2);
    chk("t6_pulse_c118", 32'(jogada_feita), 1);
    chk("t6_jogada_c118", 32'(jogada), 3);
`endif
    na(119);
    chk("t6_estado_c119", 32'(db_estado), 3);
    ate(120);
    chaves = 4'b0000;
    ate(130);
    chk("t6_estado_end", 32'(db_estado), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
